// File: rtl/seg7_scan_driver.sv
// Multiplexed DIGITS-wide seven-segment scan driver with frame-synchronous double buffering.
// Optional leading-zero blanking is built in when SEG7_LZB_EN is defined.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic [DIGITS-1:0]     DpIn,
    input  logic                  Load,
    input  logic                  Enable,
    output logic [6:0]            Seg,
    output logic                  Dp,
    output logic [DIGITS-1:0]     SegSel,
    output logic                  FrameTick
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic                frame_q, frame_d;

    logic                tick;
    logic                commit;
    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   sel_onehot;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h7E;
            4'h1: glyph = 7'h30;
            4'h2: glyph = 7'h6D;
            4'h3: glyph = 7'h79;
            4'h4: glyph = 7'h33;
            4'h5: glyph = 7'h5B;
            4'h6: glyph = 7'h5F;
            4'h7: glyph = 7'h70;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h73;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h1F;
            4'hC: glyph = 7'h4E;
            4'hD: glyph = 7'h3D;
            4'hE: glyph = 7'h4F;
            default: glyph = 7'h47;
        endcase
    endfunction

    assign tick   = Enable && (cnt_q == CNT_LAST);
    assign commit = tick && (idx_q == IDX_LAST);

    // Scan state and buffers
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        if (Load) begin
            pend_val_d = Value;
            pend_dp_d  = DpIn;
        end
        if (!Enable) begin
            cnt_d = '0;
            idx_d = IDX_LAST;
        end else if (tick) begin
            cnt_d = '0;
            if (commit) begin
                idx_d      = '0;
                // Load on the commit edge bypasses the pending buffer.
                disp_val_d = Load ? Value : pend_val_q;
                disp_dp_d  = Load ? DpIn  : pend_dp_q;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]        = disp_val_d[4*gi +: 4];
            assign sel_onehot[gi] = (idx_d == IDX_W'(gi));
`ifdef SEG7_LZB_EN
            if (gi == 0) begin : g_first
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = (disp_val_d[4*DIGITS-1:4*gi] == '0);
            end
`else
            assign blank[gi] = 1'b0;
`endif
        end
    endgenerate

    // Output registers only change on a tick or when the display goes dark.
    always_comb begin
        seg_d   = seg_q;
        dp_d    = dp_q;
        sel_d   = sel_q;
        frame_d = 1'b0;
        if (!Enable) begin
            seg_d = '0;
            dp_d  = 1'b0;
            sel_d = '0;
        end else if (tick) begin
            sel_d   = sel_onehot;
            seg_d   = blank[idx_d] ? 7'h00 : glyph(nib[idx_d]);
            dp_d    = disp_dp_d[idx_d];
            frame_d = commit;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q      <= '0;
            idx_q      <= IDX_LAST;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            seg_q      <= '0;
            dp_q       <= 1'b0;
            sel_q      <= '0;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            sel_q      <= sel_d;
            frame_q    <= frame_d;
        end
    end

    assign Seg       = seg_q;
    assign Dp        = dp_q;
    assign SegSel    = sel_q;
    assign FrameTick = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, PRESCALE=4); honours SEG7_LZB_EN.
module tb_seg7_scan_driver;

    localparam int D = 4;
    localparam int P = 4;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic [15:0]   Value;
    logic [3:0]    DpIn;
    logic          Load;
    logic          Enable;
    logic [6:0]    Seg;
    logic          Dp;
    logic [3:0]    SegSel;
    logic          FrameTick;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
        int         len;
    } exp_t;
    exp_t exp_q[$];

    seg7_scan_driver #(.DIGITS(D), .PRESCALE(P)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Value(Value), .DpIn(DpIn), .Load(Load),
        .Enable(Enable), .Seg(Seg), .Dp(Dp), .SegSel(SegSel), .FrameTick(FrameTick)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return t[n];
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i);
`ifdef SEG7_LZB_EN
        bit all_zero = 1'b1;
        for (int j = i; j < D; j++) if (v[4*j +: 4] != 4'h0) all_zero = 1'b0;
        if (i > 0 && all_zero) return 7'h00;
`endif
        return ref_glyph(v[4*i +: 4]);
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] dp);
        for (int i = 0; i < D; i++) begin
            exp_t e;
            e.sel = 4'(1 << i);
            e.seg = exp_seg(v, i);
            e.dp  = dp[i];
            e.ft  = (i == 0);
            e.len = (i == 0) ? 0 : P;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_slot(output int cyc);
        logic [3:0] prev;
        prev = SegSel;
        cyc  = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (SegSel == prev && cyc < 4 * P);
    endtask

    task automatic wait_frame(output bit ok);
        int c = 0;
        ok = 1'b0;
        while (c < 2 * D * P && !ok) begin
            @(negedge Clk);
            c++;
            if (FrameTick === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp);
        Value = v; DpIn = dp; Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0; Value = 16'hFFFF; DpIn = 4'hF;
    endtask

    task automatic test_reset;
        logic [11:0] want;
        Reset_n = 1'b0; Enable = 1'b1; Load = 1'b0; Value = '0; DpIn = '0;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({SegSel, Seg, Dp, FrameTick} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_hold: got sel=%b seg=%h dp=%b ft=%b want all 0", SegSel, Seg, Dp, FrameTick);
        end
        Reset_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge Clk);
            want = (c < 4) ? 12'h000 : {4'b0001, 7'h7E, (c == 4)};
            n_cmp++;
            $display("reset edge%0d sel=%b seg=%h ft=%b", c, SegSel, Seg, FrameTick);
            if ({SegSel, Seg, FrameTick} !== want) begin
                n_err++;
                $display("FAIL reset_edge%0d: got %h want %h", c, {SegSel, Seg, FrameTick}, want);
            end
        end
    endtask

    task automatic test_scan;
        bit ok; int cyc = 0; exp_t e;
        push_frame(16'h3A7F, 4'b0100);
        load(16'h3A7F, 4'b0100);
        wait_frame(ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL scan_frame_timeout: got %b want 1", ok); end
        for (int k = 0; k < D; k++) begin
            if (k > 0) wait_slot(cyc);
            e = exp_q.pop_front();
            n_cmp++;
            $display("scan slot%0d sel=%b seg=%h dp=%b ft=%b len=%0d", k, SegSel, Seg, Dp, FrameTick, cyc);
            if ({SegSel, Seg, Dp, FrameTick} !== {e.sel, e.seg, e.dp, e.ft}) begin
                n_err++;
                $display("FAIL scan_slot%0d: got %h want %h", k, {SegSel, Seg, Dp, FrameTick}, {e.sel, e.seg, e.dp, e.ft});
            end
            if (e.len != 0) begin
                n_cmp++;
                if (cyc !== e.len) begin n_err++; $display("FAIL scan_len%0d: got %0d want %0d", k, cyc, e.len); end
            end
        end
    endtask

    task automatic test_tear_free;
        bit ok; int cyc; exp_t e;
        load(16'h2222, 4'b0000);
        wait_frame(ok);
        n_cmp++;
        if (ok !== 1'b1 || Seg !== 7'h6D) begin
            n_err++;
            $display("FAIL tear_first: got ok=%b seg=%h want ok=1 seg=6d", ok, Seg);
        end
        repeat (P + 1) @(negedge Clk);
        for (int i = 2; i < D; i++) exp_q.push_back('{4'(1 << i), 7'h6D, 1'b0, 1'b0, 0});
        exp_q.push_back('{4'b0001, 7'h30, 1'b0, 1'b1, 0});
        exp_q.push_back('{4'b0010, 7'h30, 1'b0, 1'b0, 0});
        load(16'h1111, 4'b0000);
        for (int k = 0; k < D; k++) begin
            wait_slot(cyc);
            e = exp_q.pop_front();
            n_cmp++;
            $display("tear slot%0d sel=%b seg=%h ft=%b", k, SegSel, Seg, FrameTick);
            if ({SegSel, Seg, FrameTick} !== {e.sel, e.seg, e.ft}) begin
                n_err++;
                $display("FAIL tear_slot%0d: got %h want %h", k, {SegSel, Seg, FrameTick}, {e.sel, e.seg, e.ft});
            end
        end
    endtask

    task automatic test_coincident;
        int c = 0; int cyc = 0; exp_t e;
        do begin @(negedge Clk); c++; end while (SegSel !== 4'b1000 && c < 4 * D * P);
        n_cmp++;
        if (SegSel !== 4'b1000) begin n_err++; $display("FAIL coinc_find: got %b want 1000", SegSel); end
        repeat (P - 1) @(negedge Clk);
        push_frame(16'h0008, 4'b0001);
        load(16'h0008, 4'b0001);
        for (int k = 0; k < D; k++) begin
            if (k > 0) wait_slot(cyc);
            e = exp_q.pop_front();
            n_cmp++;
            $display("coinc slot%0d sel=%b seg=%h dp=%b ft=%b", k, SegSel, Seg, Dp, FrameTick);
            if ({SegSel, Seg, Dp, FrameTick} !== {e.sel, e.seg, e.dp, e.ft} || (e.len != 0 && cyc != e.len)) begin
                n_err++;
                $display("FAIL coinc_slot%0d: got %h len=%0d want %h len=%0d", k,
                         {SegSel, Seg, Dp, FrameTick}, cyc, {e.sel, e.seg, e.dp, e.ft}, e.len);
            end
        end
    endtask

    task automatic test_lzb;
        bit ok; int cyc; exp_t e;
        push_frame(16'h0050, 4'b0000);
        load(16'h0050, 4'b0000);
        wait_frame(ok);
        for (int k = 0; k < D; k++) begin
            if (k > 0) wait_slot(cyc);
            e = exp_q.pop_front();
            n_cmp++;
            $display("lzb slot%0d sel=%b seg=%h dp=%b", k, SegSel, Seg, Dp);
            if (ok !== 1'b1 || {SegSel, Seg, Dp} !== {e.sel, e.seg, e.dp}) begin
                n_err++;
                $display("FAIL lzb_slot%0d: got %h ok=%b want %h", k, {SegSel, Seg, Dp}, ok, {e.sel, e.seg, e.dp});
            end
        end
    endtask

    task automatic test_enable;
        logic [11:0] want;
        @(negedge Clk);
        Enable = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if ({SegSel, Seg, Dp, FrameTick} !== 13'h0) begin
            n_err++;
            $display("FAIL enable_dark: got %h want 0", {SegSel, Seg, Dp, FrameTick});
        end
        load(16'h00C1, 4'b0000);
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({SegSel, Seg, Dp, FrameTick} !== 13'h0) begin
            n_err++;
            $display("FAIL enable_hold: got %h want 0", {SegSel, Seg, Dp, FrameTick});
        end
        Enable = 1'b1;
        for (int c = 1; c <= P; c++) begin
            @(negedge Clk);
            want = (c < P) ? 12'h000 : {4'b0001, ref_glyph(4'h1), 1'b1};
            n_cmp++;
            $display("reenable edge%0d sel=%b seg=%h ft=%b", c, SegSel, Seg, FrameTick);
            if ({SegSel, Seg, FrameTick} !== want) begin
                n_err++;
                $display("FAIL reenable_edge%0d: got %h want %h", c, {SegSel, Seg, FrameTick}, want);
            end
        end
    endtask

    task automatic test_async_reset;
        #2 Reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({SegSel, Seg, Dp, FrameTick} !== 13'h0) begin
            n_err++;
            $display("FAIL async_reset: got %h want 0", {SegSel, Seg, Dp, FrameTick});
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (P) @(negedge Clk);
        n_cmp++;
        $display("post_reset sel=%b seg=%h ft=%b", SegSel, Seg, FrameTick);
        if ({SegSel, Seg, FrameTick} !== {4'b0001, 7'h7E, 1'b1}) begin
            n_err++;
            $display("FAIL post_reset: got %h want %h", {SegSel, Seg, FrameTick}, {4'b0001, 7'h7E, 1'b1});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_coincident();
        test_lzb();
        test_enable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed multi-digit seven-segment display driver: the parametrised successor to the single-digit hex decoder. It holds a DIGITS-wide hex value plus per-digit decimal points and time-multiplexes them onto one shared A–G/Dp segment bus with one-hot digit selects. A programmable refresh prescaler sets the scan rate. New values are double-buffered and committed only at frame boundaries, so the display never tears. It sits between the datapath (value producer) and the board-level display pins.

## Interface
- DIGITS, 4, number of digits scanned; legal range 1..8.
- PRESCALE, 50000, Clk cycles per digit slot; legal range 2..2^20.
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset_n  input  1  reset, asynchronous, active-low.
- Value  input  4*DIGITS  hex nibbles; nibble i = Value[4i+3:4i], digit 0 is least significant.
- DpIn  input  DIGITS  decimal point request per digit, 1 = lit.
- Load  input  1  single-cycle strobe; captures Value/DpIn into the pending buffer.
- Enable  input  1  1 = scan, 0 = display dark and scan held.
- Seg  output  7  segments {A,B,C,D,E,F,G}, Seg[6]=A, active-high.
- Dp  output  1  decimal point for the selected digit, active-high.
- SegSel  output  DIGITS  one-hot digit select, active-high; all-zero = dark.
- FrameTick  output  1  one-cycle pulse marking the start of each frame (digit 0 shown).

## Operation
- Registers:
  - pending buffer (Value, DpIn), written on Load;
  - display buffer, loaded from pending at commit;
  - prescaler cnt, width $clog2(PRESCALE);
  - digit index d, width max(1,$clog2(DIGITS)).
- Tick: Enable=1 and cnt==PRESCALE-1. cnt then wraps to 0; otherwise cnt increments while Enable=1.
- On a tick:
  - if d==DIGITS-1, then d←0, the display buffer commits, and FrameTick pulses;
  - otherwise d←d+1.
- Commit source: pending, or Value/DpIn directly if Load is high in the same cycle (bypass).
- Outputs on a tick edge:
  - SegSel←one-hot(d_next);
  - Seg←glyph(nibble d_next of the post-commit display buffer);
  - Dp←DpIn bit d_next of the post-commit buffer.
- Glyphs, Seg hex {A..G}: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=73 A=77 B=1F C=4E D=3D E=4F F=47.
- Enable=0:
  - cnt←0, d←DIGITS-1;
  - Seg, Dp, SegSel, FrameTick ←0 on the next edge;
  - Load still captures into pending.
- Load between commits: last Load wins; intermediate values are never displayed.
- DIGITS=1: every tick is a frame start and commits.

## Timing
- Reset values: Seg=0, Dp=0, SegSel=0, FrameTick=0, cnt=0, d=DIGITS-1, pending=0, display=0.
- All outputs are registered; no combinational path from inputs to outputs.
- First tick after reset release (Enable=1 throughout) occurs on the PRESCALE-th edge. It shows digit 0 and pulses FrameTick.
- Each digit is held for exactly PRESCALE cycles. Frame period is DIGITS*PRESCALE cycles.
- Load→visible latency: up to one frame plus one cycle; ≥1 cycle when Load coincides with the commit edge.
- Enable 0→1 behaves like reset release: the first tick comes PRESCALE cycles later and lands on digit 0.
- Reset_n assertion mid-frame forces reset values immediately, without waiting for Clk.

## Configuration
- SEG7_LZB_EN: leading-zero blanking.
- Defined: digit i (i≥1) is blanked (Seg=0) when nibbles DIGITS-1..i of the displayed buffer are all zero.
  - Digit 0 is never blanked.
  - SegSel and Dp behave normally for blanked digits, which keeps the duty cycle uniform.
- Undefined: every digit shows its glyph; zeros display as 7E.

## Test plan
- Reset: bench parameters DIGITS=4, PRESCALE=4. Hold Reset_n=0 → all outputs 0. Release with Enable=1 → on edge 4, SegSel=0001 and FrameTick=1 for one cycle.
- Scan: Load Value=16'h3A7F, DpIn=4'b0100, wait one frame → per slot:
  - SegSel=0001 with Seg=47;
  - SegSel=0010 with Seg=70;
  - SegSel=0100 with Seg=77, Dp=1;
  - SegSel=1000 with Seg=79;
  - each slot lasts 4 cycles.
- Tear-free: Load 16'h1111 mid-frame while showing 16'h2222 → the remaining digits still show 6D; 30 appears only from the next FrameTick.
- Coincident Load: Load 16'h0008 on the commit edge → digit 0 shows 7F in that same frame.
- Enable drop and reset: Enable=0 mid-frame → SegSel=0 next edge. Re-enable → restart at digit 0 after 4 cycles. Reset_n pulse mid-slot → outputs 0 asynchronously.
- SEG7_LZB_EN: Value=16'h0050:
  - digits 3 and 2 show Seg=00;
  - digit 1 shows 5B;
  - digit 0 shows 7E.
- Without SEG7_LZB_EN, the same value gives 7E,5B,7E,7E.
